// File: rtl/loader_pkg.sv
// Shared constants for the boot-time program loader.
// State encodings are plain 3-bit constants so older tooling can use them.
package loader_pkg;

    localparam int HDR_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] HDR0 = 3'd1;
    localparam logic [2:0] HDR1 = 3'd2;
    localparam logic [2:0] LOAD = 3'd3;
    localparam logic [2:0] CHK  = 3'd4;
    localparam logic [2:0] DONE = 3'd5;
    localparam logic [2:0] ERR  = 3'd6;

endpackage

// File: rtl/prog_loader_if.sv
// Byte-stream input, instruction-memory write port and core status.
// master drives the stream and start; slave is the loader.
interface prog_loader_if #(
    parameter int ADDR_WIDTH = 64,
    parameter int INST_WIDTH = 32
);
    logic                  start;
    logic                  in_valid;
    logic [7:0]            in_data;
    logic                  in_ready;
    logic                  mem_wr_en;
    logic [ADDR_WIDTH-1:0] mem_wr_addr;
    logic [INST_WIDTH-1:0] mem_wr_data;
    logic                  core_hold;
    logic                  done;
    logic                  error;

    modport master (
        output start, in_valid, in_data,
        input  in_ready, mem_wr_en, mem_wr_addr, mem_wr_data,
        input  core_hold, done, error
    );

    modport slave (
        input  start, in_valid, in_data,
        output in_ready, mem_wr_en, mem_wr_addr, mem_wr_data,
        output core_hold, done, error
    );
endinterface

// File: rtl/word_assembler.sv
// Packs little-endian bytes into 32-bit words; word_valid flags the
// cycle in which the 4th byte is presented (word is combinational then).
module word_assembler
    import loader_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    input  logic [7:0]  byte_in,
    output logic        word_valid,
    output logic [31:0] word
);
    logic [1:0]  bcnt;
    logic [23:0] sr;

    assign word_valid = en && (bcnt == 2'(BYTES_PER_WORD - 1));
    assign word       = {byte_in, sr};

    // Shift earlier bytes down so byte0 ends in the low lane.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            bcnt <= '0;
            sr   <= '0;
        end else if (clr) begin
            bcnt <= '0;
        end else if (en) begin
            bcnt <= bcnt + 2'd1;
            sr   <= {byte_in, sr[23:8]};
        end
    end
endmodule

// File: rtl/prog_loader.sv
// Boot loader: header N, N little-endian words into imem, then releases core.
// Define LOADER_CHKSUM_EN to require a trailing XOR checksum byte.
module prog_loader
    import loader_pkg::*;
#(
    parameter int INST_WIDTH = 32,
    parameter int DEPTH      = 80,
    parameter int ADDR_WIDTH = 64
) (
    input  logic          clk,
    input  logic          rst,
    prog_loader_if.slave  bus
);
    logic [2:0]  state, state_nx;
    logic        ready_nx;
    logic [7:0]  n_lo;
    logic [15:0] n_words, n_hdr, wcnt;
    logic        acc, start_go, word_valid, last_word;
    logic [31:0] word;
`ifdef LOADER_CHKSUM_EN
    logic [7:0]  csum;
`endif

    assign acc       = bus.in_valid && bus.in_ready;
    assign start_go  = bus.start &&
                       (state == IDLE || state == DONE || state == ERR);
    assign n_hdr     = {bus.in_data, n_lo};
    assign last_word = word_valid && (wcnt == n_words - 16'd1);

    word_assembler u_asm (
        .clk        (clk),
        .rst        (rst),
        .clr        (start_go),
        .en         (acc && state == LOAD),
        .byte_in    (bus.in_data),
        .word_valid (word_valid),
        .word       (word)
    );

    // Next-state and next-ready decode.
    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE, DONE, ERR: if (bus.start) state_nx = HDR0;
            HDR0: if (acc) state_nx = HDR1;
            HDR1: begin
                if (acc) begin
                    if (n_hdr == 16'd0 || n_hdr > 16'(DEPTH))
                        state_nx = ERR;
                    else
                        state_nx = LOAD;
                end
            end
`ifdef LOADER_CHKSUM_EN
            LOAD: if (last_word) state_nx = CHK;
            CHK: begin
                if (acc)
                    state_nx = (bus.in_data == csum) ? DONE : ERR;
            end
`else
            LOAD: begin
                if (bus.mem_wr_en && wcnt == n_words - 16'd1)
                    state_nx = DONE;
            end
`endif
            default: state_nx = IDLE;
        endcase
        ready_nx = (state_nx == HDR0) || (state_nx == HDR1) ||
                   (state_nx == LOAD) || (state_nx == CHK);
`ifndef LOADER_CHKSUM_EN
        // Stop taking bytes while the final word's strobe is in flight.
        if (last_word) ready_nx = 1'b0;
`endif
    end

    // Registered state, outputs, counters and header capture.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= IDLE;
            bus.in_ready    <= 1'b0;
            bus.mem_wr_en   <= 1'b0;
            bus.mem_wr_addr <= '0;
            bus.mem_wr_data <= '0;
            bus.core_hold   <= 1'b1;
            bus.done        <= 1'b0;
            bus.error       <= 1'b0;
            n_lo            <= '0;
            n_words         <= '0;
            wcnt            <= '0;
`ifdef LOADER_CHKSUM_EN
            csum            <= '0;
`endif
        end else begin
            state         <= state_nx;
            bus.in_ready  <= ready_nx;
            bus.done      <= (state_nx == DONE);
            bus.error     <= (state_nx == ERR);
            bus.core_hold <= (state_nx != DONE);
            bus.mem_wr_en <= word_valid;
            if (word_valid) begin
                bus.mem_wr_addr <= ADDR_WIDTH'(wcnt);
                bus.mem_wr_data <= INST_WIDTH'(word);
            end
            if (start_go)
                wcnt <= '0;
            else if (bus.mem_wr_en)
                wcnt <= wcnt + 16'd1;
            if (acc && state == HDR0) n_lo <= bus.in_data;
            if (acc && state == HDR1) n_words <= n_hdr;
`ifdef LOADER_CHKSUM_EN
            if (start_go)
                csum <= '0;
            else if (acc && (state == HDR0 || state == HDR1 || state == LOAD))
                csum <= csum ^ bus.in_data;
`endif
        end
    end
endmodule

// File: tb/tb_prog_loader.sv
// Randomized scoreboard bench for prog_loader.
// Expected writes are queued by the stimulus and popped by a write monitor.
module tb_prog_loader;
    localparam int DEPTH = 80;

    typedef struct {
        logic [63:0] addr;
        logic [31:0] data;
    } wr_t;

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;
    wr_t  exp_q[$];
    logic [31:0] words [0:127];

    prog_loader_if #(.ADDR_WIDTH(64), .INST_WIDTH(32)) bus ();

    prog_loader #(.INST_WIDTH(32), .DEPTH(DEPTH), .ADDR_WIDTH(64)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Write monitor: every strobe must match the head of the queue.
    always @(negedge clk) begin
        if (rst === 1'b1 && bus.mem_wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_write: addr %h data %h",
                         bus.mem_wr_addr, bus.mem_wr_data);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                chk("wr_addr", bus.mem_wr_addr, e.addr);
                chk("wr_data", 64'(bus.mem_wr_data), 64'(e.data));
            end
        end
    end

    task automatic send_byte(input logic [7:0] b, input int gap);
        int idle;
        int t;
        idle = (gap == 2) ? int'($urandom_range(0, 2)) : gap;
        repeat (idle) begin
            bus.in_valid = 1'b0;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        t = 0;
        while (bus.in_ready !== 1'b1 && t < 20) begin
            @(posedge clk); #1;
            t++;
        end
        if (t >= 20) begin
            n_checks++;
            n_fail++;
            $display("FAIL ready_timeout: in_ready %b expected 1", bus.in_ready);
        end else begin
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(posedge clk); #1;
        bus.start = 1'b0;
    endtask

    // Drives one frame; the expected outcome comes from the frame rules.
    task automatic run_frame(input int n, input int gap, input bit mid_start,
                             input bit bad_sum);
        logic [7:0]  sum;
        logic [7:0]  b;
        logic [15:0] nh;
        bit ok;
        bit exp_done;
        int t;
        ok = (n >= 1 && n <= DEPTH);
        nh = n[15:0];
        pulse_start();
        chk("start_done_clr", 64'(bus.done), 64'd0);
        chk("start_err_clr", 64'(bus.error), 64'd0);
        chk("start_hold", 64'(bus.core_hold), 64'd1);
        chk("start_ready", 64'(bus.in_ready), 64'd1);
        if (ok)
            for (int i = 0; i < n; i++)
                exp_q.push_back('{addr: 64'(i), data: words[i]});
        sum = 8'h00;
        b = nh[7:0];  sum ^= b; send_byte(b, gap);
        b = nh[15:8]; sum ^= b; send_byte(b, gap);
        if (!ok) begin
            chk("hdr_error", 64'(bus.error), 64'd1);
            chk("hdr_ready", 64'(bus.in_ready), 64'd0);
            chk("hdr_hold", 64'(bus.core_hold), 64'd1);
            chk("hdr_done", 64'(bus.done), 64'd0);
            repeat (3) @(posedge clk);
            #1;
            chk("hdr_no_write", 64'(exp_q.size()), 64'd0);
            return;
        end
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < 4; j++) begin
                b = words[i][8*j +: 8];
                sum ^= b;
                if (mid_start && i == 1 && j == 1) bus.start = 1'b1;
                send_byte(b, gap);
                bus.start = 1'b0;
            end
        end
`ifdef LOADER_CHKSUM_EN
        send_byte(bad_sum ? (sum ^ 8'h01) : sum, gap);
        exp_done = !bad_sum;
`else
        chk("last_strobe", 64'(bus.mem_wr_en), 64'd1);
        chk("done_early", 64'(bus.done), 64'd0);
        @(posedge clk); #1;
        chk("done_timing", 64'(bus.done), 64'd1);
        exp_done = 1'b1;
        if (bad_sum) exp_done = 1'b1;
`endif
        t = 0;
        while (bus.done !== 1'b1 && bus.error !== 1'b1 && t < 8) begin
            @(posedge clk); #1;
            t++;
        end
        chk("end_done", 64'(bus.done), 64'(exp_done));
        chk("end_error", 64'(bus.error), 64'(!exp_done));
        chk("end_hold", 64'(bus.core_hold), 64'(!exp_done));
        chk("end_ready", 64'(bus.in_ready), 64'd0);
        @(posedge clk); #1;
        chk("pending_writes", 64'(exp_q.size()), 64'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_ready"}, 64'(bus.in_ready), 64'd0);
        chk({tag, "_wr_en"}, 64'(bus.mem_wr_en), 64'd0);
        chk({tag, "_addr"}, bus.mem_wr_addr, 64'd0);
        chk({tag, "_data"}, 64'(bus.mem_wr_data), 64'd0);
        chk({tag, "_hold"}, 64'(bus.core_hold), 64'd1);
        chk({tag, "_done"}, 64'(bus.done), 64'd0);
        chk({tag, "_error"}, 64'(bus.error), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst          = 1'b0;
        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        #12;
        check_reset_vals("reset");
        #10 rst = 1'b1;
        @(posedge clk); #1;

        words[0] = 32'h00A00513;
        words[1] = 32'h00B00593;
        words[2] = 32'h00B58633;
        run_frame(3, 0, 1'b0, 1'b0);

        run_frame(0, 0, 1'b0, 1'b0);
        run_frame(81, 0, 1'b0, 1'b0);

        words[0] = $urandom;
        words[1] = $urandom;
        run_frame(2, 1, 1'b0, 1'b0);

        // Abort a load after six payload bytes; only word 0 completes.
        words[0] = 32'hCAFEF00D;
        words[1] = 32'h12345678;
        pulse_start();
        exp_q.push_back('{addr: 64'd0, data: words[0]});
        send_byte(8'h03, 0);
        send_byte(8'h00, 0);
        for (int k = 0; k < 6; k++) send_byte(words[k / 4][8*(k % 4) +: 8], 0);
        rst = 1'b0;
        #1;
        check_reset_vals("midload_rst");
        chk("midload_word0", 64'(exp_q.size()), 64'd0);
        exp_q.delete();
        #3 rst = 1'b1;
        @(posedge clk); #1;
        words[0] = 32'h00000013;
        run_frame(1, 0, 1'b0, 1'b0);

        for (int i = 0; i < 4; i++) words[i] = $urandom;
        run_frame(4, 0, 1'b1, 1'b0);

        for (int f = 0; f < 6; f++) begin
            n = $urandom_range(1, 8);
            for (int i = 0; i < n; i++) words[i] = $urandom;
            run_frame(n, 2, 1'b0, 1'b0);
        end
        for (int i = 0; i < DEPTH; i++) words[i] = $urandom;
        run_frame(DEPTH, 0, 1'b0, 1'b0);
        run_frame(int'($urandom_range(81, 65535)), 2, 1'b0, 1'b0);

`ifdef LOADER_CHKSUM_EN
        words[0] = 32'h00000013;
        run_frame(1, 0, 1'b0, 1'b0);
        run_frame(1, 0, 1'b0, 1'b1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/prog_loader.md
Name: prog_loader

Overview:
- Boot-time instruction loader directly upstream of the instruction memory of the single-cycle core.
- Receives a framed byte stream over a valid/ready handshake and assembles little-endian 32-bit instructions.
- Writes each instruction into instruction memory at consecutive word addresses (PC is word-indexed, PC+1 per instruction).
- Holds the core in reset until a complete, valid image is loaded.

Parameters:
- INST_WIDTH, 32, instruction word width; fixed at 4 bytes per word.
- DEPTH, 80, instruction memory depth in words; upper bound on the loaded word count.
- ADDR_WIDTH, 64, width of the write address, matching the PC width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle pulse; begins a new load from IDLE, DONE or ERR.
- in_valid  input  1  a byte is presented on in_data.
- in_data  input  8  stream byte.
- in_ready  output  1  loader accepts a byte this cycle.
- mem_wr_en  output  1  one-cycle instruction-memory write strobe.
- mem_wr_addr  output  ADDR_WIDTH  word address, 0..N-1.
- mem_wr_data  output  INST_WIDTH  assembled instruction.
- core_hold  output  1  1 holds the core in reset; 0 releases it.
- done  output  1  level; image loaded successfully.
- error  output  1  level; framing, length or checksum fault.

Behaviour:
- Reset (rst=0, asynchronous), all outputs registered:
  - state=IDLE, in_ready=0, mem_wr_en=0, mem_wr_addr=0, mem_wr_data=0.
  - core_hold=1, done=0, error=0; byte counter, word counter and checksum cleared.
  - Reset asserted mid-load aborts immediately; partial memory contents are ignored.
- Byte transfer: a byte transfers on a rising edge with in_valid=1 and in_ready=1. in_ready depends on state only, never on in_valid.
- Frame format: 2 header bytes carrying word count N (16-bit, low byte first), then N×4 payload bytes (each word little-endian, byte0=bits[7:0]).
- States:
  - IDLE: in_ready=0. On start: go to HDR0; clear done, error and counters; core_hold=1.
  - HDR0: in_ready=1. Capture N[7:0], go to HDR1.
  - HDR1: in_ready=1. Capture N[15:8]. If N==0 or N>DEPTH, go to ERR; else go to LOAD.
  - LOAD: in_ready=1. Shift bytes into a 32-bit assembly register. When the 4th byte of a word is accepted at edge k:
    - at edge k+1: mem_wr_en=1 for exactly one cycle, with mem_wr_addr=word index and the assembled word on mem_wr_data.
    - The word counter increments at the same edge.
    - A byte can be accepted on every cycle; the write strobe overlaps acceptance of the next word's bytes.
  - After the last word: go to DONE (or CHK when the optional feature is on).
  - DONE: in_ready=0, done=1, core_hold=0. done rises on the cycle after the final mem_wr_en pulse.
  - ERR: in_ready=0, error=1, core_hold=1.
- start is ignored while in HDR0, HDR1, LOAD or CHK.
- In DONE or ERR, start re-enters HDR0: done and error clear and core_hold returns to 1 on the next edge.
- mem_wr_addr holds its last value between strobes. Word addresses never wrap, because N≤DEPTH is checked.
- in_valid=0 stalls any state indefinitely; no timeout.

Optional Feature:
- Macro: LOADER_CHKSUM_EN.
- Defined:
  - A trailing checksum byte follows the payload; LOAD goes to CHK after the last word (in_ready=1 in CHK).
  - Expected value: 8-bit XOR of all header and payload bytes.
  - On acceptance of the checksum byte: match goes to DONE, mismatch goes to ERR. Flags update on the next edge.
  - Memory writes already performed are not undone; core_hold stays 1 on mismatch.
- Undefined: no CHK state, no checksum byte; behaviour exactly as in Behaviour.

Decomposition:
- Package loader_pkg:
  - state enum {IDLE, HDR0, HDR1, LOAD, CHK, DONE, ERR}.
  - HDR_BYTES=2, BYTES_PER_WORD=4.
- Sub-module word_assembler:
  - Byte shift register plus a 2-bit byte counter.
  - Outputs word_valid and the 32-bit word.
  - Reused later for data-memory preload.

Test Plan:
- Load N=3: bytes 03 00, 13 05 A0 00, 93 05 B0 00, 33 86 B5 00 → writes addr0=0x00A00513, addr1=0x00B00593, addr2=0x00B58633. done=1 and core_hold=0 one cycle after the third strobe.
- Header N=0 → ERR after HDR1, error=1, in_ready=0, no mem_wr_en. Header N=81 (DEPTH=80) → same response.
- in_valid toggled 1/0 every cycle during N=2 → identical write data and addresses, two strobes only.
- rst pulled low after 6 payload bytes → all outputs at reset values immediately. A fresh start plus a full N=1 frame writes addr0 correctly.
- start pulse during LOAD → ignored. start in DONE → done=0 and core_hold=1 next cycle, new frame accepted.
- With LOADER_CHKSUM_EN: N=1, word 0x00000013 → correct checksum 0x12 gives DONE; 0x13 gives ERR with core_hold=1.
